// File: rtl/pp_lane_engine_pkg.sv
// Shared types for the pp lane engine: op codes, reduction FSM states
// and a lane-slice helper for packed multi-lane buses.
package pp_lane_engine_pkg;

    typedef enum logic [3:0] {
        PP_NOP      = 4'd0,
        PP_ADD      = 4'd1,
        PP_SUB      = 4'd2,
        PP_MIN      = 4'd3,
        PP_MAX      = 4'd4,
        PP_EQ       = 4'd5,
        PP_LT       = 4'd6,
        PP_GT       = 4'd7,
        PP_SUM      = 4'd8,
        PP_COUNT_GT = 4'd9
    } pp_cmd_e;

    localparam logic [3:0] PP_CMD_SUM      = 4'd8;
    localparam logic [3:0] PP_CMD_COUNT_GT = 4'd9;

    typedef enum logic {
        RED_IDLE,
        RED_ACCUM
    } red_state_e;

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/pp_lane_engine_if.sv
// Streaming bundle for the lane engine: input beat channel (valid/ready,
// cmd, in1, in2, in_last) and result channel (valid/ready, out, out1, out_last).
interface pp_lane_engine_if #(
    parameter int NUM_SIZE      = 32,
    parameter int CMD_SIZE_LOG2 = 3,
    parameter int LANES         = 4
);
    localparam int CMD_W = 2 ** CMD_SIZE_LOG2;

    logic                      in_valid;
    logic                      in_ready;
    logic [CMD_W-1:0]          cmd;
    logic [LANES*NUM_SIZE-1:0] in1;
    logic [LANES*NUM_SIZE-1:0] in2;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES-1:0]          out;
    logic [LANES*NUM_SIZE-1:0] out1;
    logic                      out_last;

    modport slave (
        input  in_valid, cmd, in1, in2, in_last, out_ready,
        output in_ready, out_valid, out, out1, out_last
    );

    modport master (
        output in_valid, cmd, in1, in2, in_last, out_ready,
        input  in_ready, out_valid, out, out1, out_last
    );

endinterface

// File: rtl/pp_lane_engine_fifo.sv
// Result FIFO (stage 2). Ports: clk, rst_n (async low), push_i/data_i,
// pop_i, data_o (head), valid_o (non-empty), count_o (occupancy).
module pp_lane_engine_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_i) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/pp_lane_engine.sv
// LANES-wide element-wise ALU plus SUM / COUNT_GT column reductions.
// Ports: clk, reset (async low), io (slave stream bundle), err (sticky bad cmd).
module pp_lane_engine
    import pp_lane_engine_pkg::*;
#(
    parameter int NUM_SIZE      = 32,
    parameter int CMD_SIZE_LOG2 = 3,
    parameter int LANES         = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int SIGNED        = 1
) (
    input  logic              clk,
    input  logic              reset,
    pp_lane_engine_if.slave   io,
    output logic              err
);
    localparam int CMD_W = 2 ** CMD_SIZE_LOG2;
    localparam int W     = LANES * NUM_SIZE;
    localparam int FW    = LANES * (NUM_SIZE + 1) + 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    logic          accept;
    logic          known;
    logic          is_red;
    pp_cmd_e       op;
    pp_cmd_e       red_mode;
    logic [CW-1:0] fifo_count;
    logic [FW-1:0] head;
    logic          head_valid;

    logic [W-1:0]     ew_val, red_val;
    logic [LANES-1:0] ew_flag, red_flag;

    red_state_e       state_q, state_d;
    pp_cmd_e          mode_q, mode_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [LANES-1:0] flag_q, flag_d;
    logic             s1_valid_q, s1_valid_d;
    logic [FW-1:0]    s1_data_q, s1_data_d;
    logic             err_q, err_d;

    // Stage 1 never stalls: a beat is only taken if both S1 and the FIFO
    // have a guaranteed slot for it.
    assign io.in_ready = reset &&
        ((CW+1)'(fifo_count) + (CW+1)'(s1_valid_q) < (CW+1)'(FIFO_DEPTH));
    assign accept = io.in_valid && io.in_ready;

    assign known    = (io.cmd <= CMD_W'(PP_CMD_COUNT_GT));
    assign op       = known ? pp_cmd_e'(io.cmd[3:0]) : PP_NOP;
    // While a group is open the beat's cmd is ignored.
    assign is_red   = (state_q == RED_ACCUM) || (op == PP_SUM) ||
                      (op == PP_COUNT_GT);
    assign red_mode = (state_q == RED_ACCUM) ? mode_q : op;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int LO = lane_lo(i, NUM_SIZE);
        localparam int N  = NUM_SIZE;

        logic [N-1:0] a, b, acc, v, rv;
        logic [N:0]   add, sub, rsum;
        logic         eq, lt, gt, add_ov, sub_ov, sum_ov, f, rf;

        assign a    = io.in1[LO +: N];
        assign b    = io.in2[LO +: N];
        assign acc  = acc_q[LO +: N];
        assign add  = {1'b0, a} + {1'b0, b};
        assign sub  = {1'b0, a} - {1'b0, b};
        assign rsum = {1'b0, acc} + {1'b0, a};
        assign eq   = (a == b);
        assign lt   = (SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);
        assign gt   = (SIGNED != 0) ? ($signed(a) > $signed(b)) : (a > b);

        // Signed overflow: operand signs vs result sign; unsigned: bit N.
        assign add_ov = (SIGNED != 0) ?
            ((a[N-1] == b[N-1]) && (add[N-1] != a[N-1])) : add[N];
        assign sub_ov = (SIGNED != 0) ?
            ((a[N-1] != b[N-1]) && (sub[N-1] != a[N-1])) : sub[N];
        assign sum_ov = (SIGNED != 0) ?
            ((acc[N-1] == a[N-1]) && (rsum[N-1] != acc[N-1])) : rsum[N];

        always_comb begin
            v = '0;
            f = 1'b0;
            unique case (op)
                PP_ADD: begin v = add[N-1:0]; f = add_ov; end
                PP_SUB: begin v = sub[N-1:0]; f = sub_ov; end
                PP_MIN: begin v = lt ? a : b; f = eq; end
                PP_MAX: begin v = gt ? a : b; f = eq; end
                PP_EQ:  begin v = a; f = eq; end
                PP_LT:  begin v = a; f = lt; end
                PP_GT:  begin v = a; f = gt; end
                default: ;
            endcase
        end

        always_comb begin
            rv = acc;
            rf = flag_q[i];
            if (red_mode == PP_SUM) begin
                rv = rsum[N-1:0];
                rf = flag_q[i] | sum_ov;
            end else begin
                if (gt && (acc != '1)) rv = acc + N'(1);
                rf = (rv == '1);
            end
        end

        assign ew_val[LO +: N]  = v;
        assign ew_flag[i]       = f;
        assign red_val[LO +: N] = rv;
        assign red_flag[i]      = rf;
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        acc_d      = acc_q;
        flag_d     = flag_q;
        err_d      = err_q;
        s1_valid_d = 1'b0;
        s1_data_d  = '0;
        if (accept) begin
            if ((state_q == RED_IDLE) && !known) err_d = 1'b1;
            if (!is_red) begin
                s1_valid_d = 1'b1;
                s1_data_d  = {1'b1, ew_flag, ew_val};
            end else if (io.in_last) begin
                s1_valid_d = 1'b1;
                s1_data_d  = {1'b1, red_flag, red_val};
                acc_d      = '0;
                flag_d     = '0;
                state_d    = RED_IDLE;
            end else begin
                acc_d   = red_val;
                flag_d  = red_flag;
                mode_d  = red_mode;
                state_d = RED_ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RED_IDLE;
            mode_q     <= PP_NOP;
            acc_q      <= '0;
            flag_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            flag_q     <= flag_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            err_q      <= err_d;
        end
    end

    pp_lane_engine_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (s1_valid_q),
        .data_i  (s1_data_q),
        .pop_i   (head_valid && io.out_ready),
        .data_o  (head),
        .valid_o (head_valid),
        .count_o (fifo_count)
    );

    assign io.out_valid = head_valid;
    assign io.out1      = head_valid ? head[W-1:0] : '0;
    assign io.out       = head_valid ? head[W +: LANES] : '0;
    assign io.out_last  = head_valid & head[FW-1];
    assign err          = err_q;

endmodule

// File: tb/tb_pp_lane_engine.sv
// Scoreboard bench: unsigned and signed engines driven with identical beats,
// each checked against an arithmetic reference model.
module tb_pp_lane_engine;

    typedef struct packed {
        logic [127:0] v;
        logic [3:0]   f;
        logic         l;
    } exp_t;

    logic clk;
    logic rst_n;
    logic err0, err1;

    pp_lane_engine_if #(.NUM_SIZE(32), .CMD_SIZE_LOG2(3), .LANES(4)) bus0 ();
    pp_lane_engine_if #(.NUM_SIZE(32), .CMD_SIZE_LOG2(3), .LANES(4)) bus1 ();

    pp_lane_engine #(
        .NUM_SIZE(32), .CMD_SIZE_LOG2(3), .LANES(4), .FIFO_DEPTH(4), .SIGNED(0)
    ) u0 (.clk(clk), .reset(rst_n), .io(bus0.slave), .err(err0));

    pp_lane_engine #(
        .NUM_SIZE(32), .CMD_SIZE_LOG2(3), .LANES(4), .FIFO_DEPTH(4), .SIGNED(1)
    ) u1 (.clk(clk), .reset(rst_n), .io(bus1.slave), .err(err1));

    int checks = 0;
    int passes = 0;
    int sent = 0;
    int popped0 = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    bit rdy_rand = 0;
    bit rdy_val = 1;

    // Reference model state, one copy per engine (0 unsigned, 1 signed).
    bit          m_open [2];
    logic [7:0]  m_mode [2];
    logic [31:0] m_acc  [2][4];
    bit          m_fl   [2][4];
    bit          m_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic longint val(input int d, input logic [31:0] a);
        return d != 0 ? longint'($signed(a)) : longint'({32'b0, a});
    endfunction

    function automatic bit ovf(input int d, input longint r);
        if (d != 0) return (r < -64'sd2147483648) || (r > 64'sd2147483647);
        return (r < 0) || (r > 64'sd4294967295);
    endfunction

    function automatic bit step(input int d, input logic [7:0] c,
                                input logic [127:0] x, input logic [127:0] y,
                                input bit last, output exp_t e);
        longint a, b, r;
        logic [31:0] ua, ub;
        bit red;
        e = '0;
        e.l = 1'b1;
        red = m_open[d] || (c == 8'd8) || (c == 8'd9);
        if (!red) begin
            if (c > 8'd9) m_err = 1'b1;
            for (int i = 0; i < 4; i++) begin
                ua = x[i*32 +: 32];
                ub = y[i*32 +: 32];
                a = val(d, ua);
                b = val(d, ub);
                case (c)
                    8'd1: begin r = a + b; e.v[i*32 +: 32] = r[31:0]; e.f[i] = ovf(d, r); end
                    8'd2: begin r = a - b; e.v[i*32 +: 32] = r[31:0]; e.f[i] = ovf(d, r); end
                    8'd3: begin e.v[i*32 +: 32] = (a < b) ? ua : ub; e.f[i] = (a == b); end
                    8'd4: begin e.v[i*32 +: 32] = (a > b) ? ua : ub; e.f[i] = (a == b); end
                    8'd5: begin e.v[i*32 +: 32] = ua; e.f[i] = (a == b); end
                    8'd6: begin e.v[i*32 +: 32] = ua; e.f[i] = (a < b); end
                    8'd7: begin e.v[i*32 +: 32] = ua; e.f[i] = (a > b); end
                    default: ;
                endcase
            end
            return 1'b1;
        end
        if (!m_open[d]) begin
            m_open[d] = 1'b1;
            m_mode[d] = c;
            for (int i = 0; i < 4; i++) begin
                m_acc[d][i] = '0;
                m_fl[d][i] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            ua = x[i*32 +: 32];
            ub = y[i*32 +: 32];
            if (m_mode[d] == 8'd8) begin
                r = val(d, m_acc[d][i]) + val(d, ua);
                m_fl[d][i] = m_fl[d][i] | ovf(d, r);
                m_acc[d][i] = r[31:0];
            end else begin
                if (val(d, ua) > val(d, ub) && m_acc[d][i] != 32'hFFFFFFFF)
                    m_acc[d][i] = m_acc[d][i] + 32'd1;
                m_fl[d][i] = (m_acc[d][i] == 32'hFFFFFFFF);
            end
        end
        if (!last) return 1'b0;
        for (int i = 0; i < 4; i++) begin
            e.v[i*32 +: 32] = m_acc[d][i];
            e.f[i] = m_fl[d][i];
        end
        m_open[d] = 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_open[0] = 1'b0;
        m_open[1] = 1'b0;
        m_err = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic idle();
        @(negedge clk);
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input logic [127:0] x,
                        input logic [127:0] y, input bit last);
        exp_t e;
        int n;
        @(negedge clk);
        bus0.in_valid = 1'b1; bus0.cmd = c; bus0.in1 = x;
        bus0.in2 = y; bus0.in_last = last;
        bus1.in_valid = 1'b1; bus1.cmd = c; bus1.in1 = x;
        bus1.in2 = y; bus1.in_last = last;
        n = 0;
        while (!(bus0.in_ready && bus1.in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            bus0.in_valid = 1'b0;
            bus1.in_valid = 1'b0;
            return;
        end
        if (step(0, c, x, y, last, e)) q0.push_back(e);
        if (step(1, c, x, y, last, e)) q1.push_back(e);
        @(posedge clk);
        sent++;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0",
                     q0.size(), q1.size());
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rw();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus0.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
            bus1.out_ready = bus0.out_ready;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus0.out_valid && bus0.out_ready) begin
            popped0++;
            if (q0.size() == 0) begin
                checks++;
                $display("FAIL u0_unexpected: got out1 %h expected none", bus0.out1);
            end else begin
                e0 = q0.pop_front();
                chk("u0_out1", bus0.out1, e0.v);
                chk("u0_out", 128'(bus0.out), 128'(e0.f));
                chk("u0_last", 128'(bus0.out_last), 128'(e0.l));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                $display("FAIL u1_unexpected: got out1 %h expected none", bus1.out1);
            end else begin
                e1 = q1.pop_front();
                chk("u1_out1", bus1.out1, e1.v);
                chk("u1_out", 128'(bus1.out), 128'(e1.f));
                chk("u1_last", 128'(bus1.out_last), 128'(e1.l));
            end
        end
    end

    initial begin
        logic [127:0] x, y;
        logic [7:0] c;
        int base;
        bus0.in_valid = 1'b0; bus0.cmd = '0; bus0.in1 = '0;
        bus0.in2 = '0; bus0.in_last = 1'b0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.cmd = '0; bus1.in1 = '0;
        bus1.in2 = '0; bus1.in_last = 1'b0; bus1.out_ready = 1'b1;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(bus0.in_ready), 128'(0));
        chk("rst_out_valid", 128'(bus0.out_valid), 128'(0));
        chk("rst_out1", bus0.out1, 128'(0));
        chk("rst_out", 128'(bus0.out), 128'(0));
        chk("rst_out_last", 128'(bus0.out_last), 128'(0));
        chk("rst_err", 128'(err0), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(bus0.in_ready), 128'(1));

        // Unsigned ADD with carry on lane 3, two-cycle latency.
        send(8'd1, {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1}, {4{32'd1}}, 1'b1);
        idle();
        chk("add_lat_n1", 128'(bus0.out_valid), 128'(0));
        @(negedge clk);
        chk("add_lat_n2", 128'(bus0.out_valid), 128'(1));
        chk("add_out1", bus0.out1, {32'd0, 32'd4, 32'd3, 32'd2});
        chk("add_flag", 128'(bus0.out), 128'(4'b1000));
        drain();

        // Signed LT.
        send(8'd6, {32'd7, 32'd0, 32'd5, 32'hFFFFFFFF},
             {32'd8, 32'hFFFFFFFD, 32'd5, 32'd0}, 1'b1);
        idle();
        @(negedge clk);
        chk("lt_flag", 128'(bus1.out), 128'(4'b1001));
        chk("lt_out1", bus1.out1, {32'd7, 32'd0, 32'd5, 32'hFFFFFFFF});
        drain();

        // Three-beat SUM, then a fresh single-beat group.
        send(8'd8, {4{32'd10}}, '0, 1'b0);
        send(8'd1, {4{32'd20}}, '0, 1'b0);
        send(8'd8, {4{32'd30}}, '0, 1'b1);
        idle();
        chk("sum_no_early", 128'(bus0.out_valid), 128'(0));
        @(negedge clk);
        chk("sum_out1", bus0.out1, {4{32'd60}});
        chk("sum_last", 128'(bus0.out_last), 128'(1));
        drain();
        send(8'd8, {4{32'd7}}, '0, 1'b1);
        idle();
        @(negedge clk);
        chk("sum_restart", bus0.out1, {4{32'd7}});
        drain();

        // Backpressure: 8 ADD beats against a stalled sink.
        rdy_val = 1'b0;
        repeat (2) @(negedge clk);
        base = popped0;
        sent = 0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(8'd1, {4{32'(i)}}, {4{32'd100}}, 1'b1);
                idle();
            end
            begin
                repeat (10) @(negedge clk);
                chk("bp_accepted", 128'(sent), 128'(4));
                chk("bp_in_ready", 128'(bus0.in_ready), 128'(0));
                rdy_val = 1'b1;
            end
        join
        drain();
        chk("bp_popped", 128'(popped0 - base), 128'(8));

        // Unknown command.
        send(8'h0F, {4{32'h12345678}}, {4{32'h9}}, 1'b1);
        idle();
        chk("err_set", 128'(err0), 128'(1));
        @(negedge clk);
        chk("bad_out1", bus0.out1, 128'(0));
        chk("bad_out", 128'(bus0.out), 128'(0));
        drain();

        // Randomized traffic with random sink stalls.
        rdy_rand = 1'b1;
        repeat (300) begin
            c = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8, 9))
                                            : 8'($urandom_range(0, 7));
            for (int i = 0; i < 4; i++) begin
                x[i*32 +: 32] = rw();
                y[i*32 +: 32] = rw();
            end
            send(c, x, y, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 4) == 0) idle();
        end
        send(8'd8, {4{32'd1}}, '0, 1'b1);
        idle();
        rdy_rand = 1'b0;
        rdy_val = 1'b1;
        drain();
        chk("err_sticky", 128'(err0), 128'(m_err));

        // Reset in the middle of an open SUM group.
        send(8'd8, {4{32'd3}}, '0, 1'b0);
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_in_ready", 128'(bus0.in_ready), 128'(0));
        chk("midrst_out_valid", 128'(bus0.out_valid), 128'(0));
        chk("midrst_err", 128'(err0), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'd8, {4{32'd5}}, '0, 1'b1);
        idle();
        @(negedge clk);
        chk("midrst_sum", bus0.out1, {4{32'd5}});
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
